// File: rtl/frame_dump_pkg.sv
// frame_dump_pkg: shared definitions for the frame dump window controller.
//   chan_state_e  per-channel window state
//   FW_DEFAULT    default frame counter width
//   LW_DEFAULT    default window length counter width
package frame_dump_pkg;

  localparam int unsigned FW_DEFAULT = 32;
  localparam int unsigned LW_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DONE   = 2'd3
  } chan_state_e;

endpackage

// File: rtl/frame_dump_chan.sv
// frame_dump_chan: one dump channel - window FSM plus remaining-frame counter.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   cfg_hit_i      configuration write addressed to this channel
//   cfg_start_i    frame number that opens the window
//   cfg_len_i      window length in frames (0 = open until reconfigured)
//   fall_i         qualified frame boundary (vsync falling edge, run gated)
//   frame_cnt_i    frame counter value before this boundary's increment
//   active_d_o     next-state window open (for edge pulse generation)
//   active_o       window open
//   done_o         window has closed
module frame_dump_chan
  import frame_dump_pkg::*;
#(
  parameter int unsigned FW = FW_DEFAULT,
  parameter int unsigned LW = LW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_hit_i,
  input  logic [FW-1:0] cfg_start_i,
  input  logic [LW-1:0] cfg_len_i,
  input  logic          fall_i,
  input  logic [FW-1:0] frame_cnt_i,
  output logic          active_d_o,
  output logic          active_o,
  output logic          done_o
);

  chan_state_e   state_q, state_d;
  logic [FW-1:0] start_q, start_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] remain_q, remain_d;

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    len_d    = len_q;
    remain_d = remain_q;
    // A config write takes priority over a frame boundary in the same cycle.
    if (cfg_hit_i) begin
      start_d = cfg_start_i;
      len_d   = cfg_len_i;
      state_d = ST_WAIT;
    end else if (fall_i) begin
      case (state_q)
        ST_WAIT: begin
          if (frame_cnt_i == start_q) begin
            state_d  = ST_ACTIVE;
            remain_d = len_q;
          end
        end
        ST_ACTIVE: begin
          // len 0 keeps the window open with remain held.
          if (len_q != '0) begin
            if (remain_q == LW'(1)) state_d = ST_DONE;
            else                    remain_d = remain_q - LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      start_q  <= '0;
      len_q    <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      len_q    <= len_d;
      remain_q <= remain_d;
    end
  end

  assign active_d_o = (state_d == ST_ACTIVE);
  assign active_o   = (state_q == ST_ACTIVE);
  assign done_o     = (state_q == ST_DONE);

endmodule

// File: rtl/frame_dump_ctrl.sv
// frame_dump_ctrl: frame-synchronous multi-channel dump window controller.
// Counts frames on the vsync falling edge and opens up to CH dump windows.
// Build option: define DUMP_LOADROM_EN to hold counting until the first
// falling edge of downloading after reset.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   VGA_VS          vertical sync (synchronous to clk)
//   downloading     ROM download in progress
//   cfg_we/cfg_ch   channel configuration write strobe / channel index
//   cfg_start       frame number that opens the window
//   cfg_len         window length in frames (0 = open until reconfigured)
//   frame_cnt       completed frames since run start
//   dump_en         per-channel window open
//   ch_done         per-channel window closed
//   dump_any        OR of dump_en
//   dump_on/off     one-cycle pulses on dump_any rising/falling
module frame_dump_ctrl
  import frame_dump_pkg::*;
#(
  parameter int unsigned CH = 2,
  parameter int unsigned FW = FW_DEFAULT,
  parameter int unsigned LW = LW_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                VGA_VS,
  input  logic                                downloading,
  input  logic                                cfg_we,
  input  logic [((CH > 1) ? $clog2(CH) : 1)-1:0] cfg_ch,
  input  logic [FW-1:0]                       cfg_start,
  input  logic [LW-1:0]                       cfg_len,
  output logic [FW-1:0]                       frame_cnt,
  output logic [CH-1:0]                       dump_en,
  output logic [CH-1:0]                       ch_done,
  output logic                                dump_any,
  output logic                                dump_on,
  output logic                                dump_off
);

  localparam int unsigned CW = (CH > 1) ? $clog2(CH) : 1;

  logic          vs_q, vs_l, vs_fall_q;
  logic          run;
  logic          fall;
  logic [FW-1:0] frame_cnt_q;
  logic [CH-1:0] en_d, en_q, done;
  logic          dump_on_q, dump_off_q;

  // The falling edge is itself registered so that frame-boundary effects
  // land two edges after VGA_VS is first sampled low.
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q      <= 1'b0;
      vs_l      <= 1'b0;
      vs_fall_q <= 1'b0;
    end else begin
      vs_q      <= VGA_VS;
      vs_l      <= vs_q;
      vs_fall_q <= vs_l & ~vs_q;
    end
  end

`ifdef DUMP_LOADROM_EN
  logic dl_q, run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dl_q  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      dl_q <= downloading;
      if (dl_q & ~downloading) run_q <= 1'b1;
    end
  end

  assign run = run_q;
`else
  logic unused_downloading;
  assign unused_downloading = downloading;
  assign run = 1'b1;
`endif

  assign fall = vs_fall_q & run;

  always_ff @(posedge clk) begin
    if (rst) frame_cnt_q <= '0;
    else if (fall) frame_cnt_q <= frame_cnt_q + FW'(1);
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    frame_dump_chan #(
      .FW (FW),
      .LW (LW)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .cfg_hit_i   (cfg_we && (cfg_ch == CW'(i))),
      .cfg_start_i (cfg_start),
      .cfg_len_i   (cfg_len),
      .fall_i      (fall),
      .frame_cnt_i (frame_cnt_q),
      .active_d_o  (en_d[i]),
      .active_o    (en_q[i]),
      .done_o      (done[i])
    );
  end

  // Pulses come from next-state dump_any so they align with the dump_en edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      dump_on_q  <= 1'b0;
      dump_off_q <= 1'b0;
    end else begin
      dump_on_q  <= (|en_d) & ~(|en_q);
      dump_off_q <= ~(|en_d) & (|en_q);
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign dump_en   = en_q;
  assign ch_done   = done;
  assign dump_any  = |en_q;
  assign dump_on   = dump_on_q;
  assign dump_off  = dump_off_q;

endmodule
